// File: rtl/regadd_cg_enable_ctrl.sv
// ----------------------------------------------------------------------------
// regadd_cg_enable_ctrl
//   Produces the EN/TE pair for the 24-bit RegisterAdd clock gate. Runs on the
//   ungated clock. Opens the gate when upstream has work, withholds REQ_READY
//   until the gated clock has had WAKE_CYC cycles to settle, counts adds in
//   flight, and closes the gate after IDLE_CYC quiet cycles.
//
//   Optional feature: define REGADD_CG_STATS_EN to enable the gated-off cycle
//   counter (OFF_CYCLES / STATS_CLR). Without it the ports remain, OFF_CYCLES
//   reads 0 and STATS_CLR is ignored.
//
// Ports
//   i_clk         ungated clock
//   i_rst_n       synchronous reset, active low
//   i_req_valid   upstream has an add to issue
//   o_req_ready   add accepted when i_req_valid & o_req_ready
//   i_retire      one-cycle pulse: one add left the RegisterAdd pipe
//   i_scan_mode   test mode, forces the gate open
//   o_gate_en     clock gate EN
//   o_gate_te     clock gate TE
//   o_inflight    outstanding add count
//   o_busy        controller not in OFF
//   o_err         sticky: retire seen with nothing in flight
//   i_stats_clr   clears o_off_cycles
//   o_off_cycles  gated-off cycle count (saturating)
// ----------------------------------------------------------------------------
module regadd_cg_enable_ctrl #(
    parameter int WAKE_CYC   = 2,
    parameter int IDLE_CYC   = 4,
    parameter int PIPE_DEPTH = 3,
    localparam int CW        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_retire,
    input  logic          i_scan_mode,
    output logic          o_gate_en,
    output logic          o_gate_te,
    output logic [CW-1:0] o_inflight,
    output logic          o_busy,
    output logic          o_err,
    input  logic          i_stats_clr,
    output logic [31:0]   o_off_cycles
);

    localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(PIPE_DEPTH);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [WW-1:0]   r_wcnt, w_wcnt_nxt;
    logic [IW-1:0]   r_icnt, w_icnt_nxt;
    logic [CW-1:0]   r_inflight, w_inflight_nxt;
    logic            r_gate_en;
    logic            r_err;
    logic            w_ready;
    logic            w_accept;
    logic            w_retire_dec;

    // A retire in the same cycle frees a slot, so a full pipe can still accept.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_ON:    w_ready = (r_inflight < DEPTH_C) | i_retire;
            S_IDLE:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    assign w_accept       = i_req_valid & w_ready;
    assign w_retire_dec   = i_retire & (r_inflight != '0);
    assign w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(w_retire_dec);

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_icnt_nxt  = r_icnt;
        case (r_state)
            S_OFF: begin
                if (i_req_valid) begin
                    w_state_nxt = S_WAKE;
                    w_wcnt_nxt  = WW'(WAKE_CYC - 1);
                end
            end
            S_WAKE: begin
                if (r_wcnt == '0) w_state_nxt = S_ON;
                else              w_wcnt_nxt  = r_wcnt - 1'b1;
            end
            S_ON: begin
                // Start the idle window once the pipe will be empty.
                if ((w_inflight_nxt == '0) && !w_accept) begin
                    w_state_nxt = S_IDLE;
                    w_icnt_nxt  = IW'(IDLE_CYC - 1);
                end
            end
            S_IDLE: begin
                if (w_accept)            w_state_nxt = S_ON;
                else if (r_icnt == '0)   w_state_nxt = S_OFF;
                else                     w_icnt_nxt  = r_icnt - 1'b1;
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_OFF;
            r_wcnt     <= '0;
            r_icnt     <= '0;
            r_inflight <= '0;
            r_gate_en  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_icnt     <= w_icnt_nxt;
            r_inflight <= w_inflight_nxt;
            // Enable follows the next state from a flop: no glitches into the latch.
            r_gate_en  <= (w_state_nxt != S_OFF);
            if (i_retire && (r_inflight == '0)) r_err <= 1'b1;
        end
    end

`ifdef REGADD_CG_STATS_EN
    logic [31:0] r_off_cycles;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_off_cycles <= '0;
        else if (i_stats_clr)
            r_off_cycles <= '0;
        else if ((r_state == S_OFF) && !r_gate_en && (r_off_cycles != 32'hFFFF_FFFF))
            r_off_cycles <= r_off_cycles + 32'd1;
    end

    assign o_off_cycles = r_off_cycles;
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = i_stats_clr;
    assign o_off_cycles       = '0;
`endif

    // Scan forces the gate open without disturbing the FSM.
    assign o_gate_en   = r_gate_en | i_scan_mode;
    assign o_gate_te   = r_gate_en | i_scan_mode;
    assign o_req_ready = w_ready;
    assign o_inflight  = r_inflight;
    assign o_busy      = (r_state != S_OFF);
    assign o_err       = r_err;

endmodule

// File: tb/tb_regadd_cg_enable_ctrl.sv
// Bench for regadd_cg_enable_ctrl: directed wake-latency / back-pressure
// checks, then randomized traffic compared cycle by cycle against a model
// phrased in terms of "gate open", "cycles since wake" and "quiet run length".
module tb_regadd_cg_enable_ctrl;
    localparam int WAKE_CYC   = 2;
    localparam int IDLE_CYC   = 4;
    localparam int PIPE_DEPTH = 3;
    localparam int CW         = $clog2(PIPE_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          retire = 1'b0;
    logic          scan_mode = 1'b0;
    logic          gate_en, gate_te;
    logic [CW-1:0] inflight;
    logic          busy, err;
    logic          stats_clr = 1'b0;
    logic [31:0]   off_cycles;

    always #5 clk = ~clk;

    regadd_cg_enable_ctrl #(
        .WAKE_CYC(WAKE_CYC), .IDLE_CYC(IDLE_CYC), .PIPE_DEPTH(PIPE_DEPTH)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_retire(retire), .i_scan_mode(scan_mode), .o_gate_en(gate_en), .o_gate_te(gate_te),
        .o_inflight(inflight), .o_busy(busy), .o_err(err), .i_stats_clr(stats_clr),
        .o_off_cycles(off_cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_on;     // gate open (controller awake)
    int          m_age;    // awake cycles completed since wake
    int          m_quiet;  // consecutive ready-phase cycles with no accept and empty pipe after
    int          m_infl;
    bit          m_err;
    logic [31:0] m_off;
    logic        last_rdy;

    task automatic model_reset();
        m_on = 0; m_age = 0; m_quiet = 0; m_infl = 0; m_err = 0; m_off = '0;
    endtask

    task automatic step(input bit v, input bit r, input bit s, input bit c, input bit rn);
        bit rdy_ph, e_rdy, acc;
        int nxt;
        @(negedge clk);
        req_valid = v; retire = r; scan_mode = s; stats_clr = c; rst_n = rn;
        #1;
        rdy_ph = m_on && (m_age >= WAKE_CYC);
        e_rdy  = rdy_ph && ((m_infl < PIPE_DEPTH) || r);
        acc    = v && e_rdy;
        last_rdy = req_ready;
        chk("ready",    {31'd0, req_ready}, {31'd0, e_rdy});
        chk("gate_en",  {31'd0, gate_en},   {31'd0, m_on | s});
        chk("gate_te",  {31'd0, gate_te},   {31'd0, m_on | s});
        chk("busy",     {31'd0, busy},      {31'd0, m_on});
        chk("inflight", 32'(inflight),      32'(m_infl));
        chk("err",      {31'd0, err},       {31'd0, m_err});
`ifdef REGADD_CG_STATS_EN
        chk("off_cyc",  off_cycles,         m_off);
`else
        chk("off_cyc",  off_cycles,         32'd0);
`endif
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            if (r && m_infl == 0) m_err = 1;
            if (c)                                     m_off = '0;
            else if (!m_on && m_off != 32'hFFFF_FFFF)  m_off = m_off + 1;
            nxt = m_infl + (acc ? 1 : 0) - ((r && m_infl != 0) ? 1 : 0);
            if (!m_on) begin
                if (v) begin m_on = 1; m_age = 0; m_quiet = 0; end
            end else begin
                if (rdy_ph) begin
                    if (!acc && nxt == 0) m_quiet++;
                    else                  m_quiet = 0;
                    // One quiet cycle to notice the empty pipe, then the idle window.
                    if (m_quiet == IDLE_CYC + 1) m_on = 0;
                end
                if (m_age < 1000) m_age++;
            end
            m_infl = nxt;
        end
    endtask

    initial begin
        int first_rdy;
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Wake latency: valid held from cycle 0, ready expected at cycle 3.
        first_rdy = -1;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 0, 1);
            if (last_rdy && first_rdy < 0) first_rdy = k;
            if (first_rdy >= 0 && k >= first_rdy + 3) break;
        end
        chk("wake_lat", 32'(first_rdy), 32'd3);
        // Pipe full: the next request must stall.
        step(1, 0, 0, 0, 1);
        chk("full_stall", {31'd0, last_rdy}, 32'd0);
        // Retire + request together: accepted, count unchanged.
        step(1, 1, 0, 0, 1);
        chk("swap_rdy", {31'd0, last_rdy}, 32'd1);
        step(0, 0, 0, 0, 1);
        chk("swap_infl", 32'(inflight), 32'(PIPE_DEPTH));
        // Drain and let the gate close; then a stretch of OFF cycles for stats.
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 1);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1);
        chk("closed", {31'd0, gate_en}, 32'd0);
        // Stray retire in OFF sets ERR; scan forces the gate open.
        step(0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Randomized traffic with varying request density.
        for (int blk = 0; blk < 30; blk++) begin
            int vp;
            vp = (blk % 4 == 0) ? 0 : (blk % 4 == 1) ? 15 : (blk % 4 == 2) ? 60 : 95;
            for (int k = 0; k < 80; k++) begin
                bit v, r, s, c, rn;
                v  = ($urandom_range(99, 0) < vp);
                r  = (m_infl > 0) ? ($urandom_range(99, 0) < 40) : ($urandom_range(99, 0) < 1);
                s  = ($urandom_range(99, 0) < 4);
                c  = ($urandom_range(99, 0) < 3);
                rn = ($urandom_range(299, 0) != 0);
                step(v, r, s, c, rn);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
